// File: rtl/core_io_bridge.sv
// core_io_bridge: buffers core port-writes in a TX FIFO for the host, and holds one host word for core din.
// Optional build macro CORE_IO_BRIDGE_STATS_EN adds saturating tx_words/rx_words counters.
`default_nettype none

module core_io_bridge #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic [DW-1:0] core_dout,
   input  logic          core_wr,
   input  logic          core_rd,
   output logic [DW-1:0] core_din,
   output logic          core_din_vld,
   output logic          core_stall,
   output logic [DW-1:0] host_tx_data,
   output logic          host_tx_valid,
   input  logic          host_tx_ready,
   input  logic [DW-1:0] host_rx_data,
   input  logic          host_rx_valid,
   output logic          host_rx_ready
`ifdef CORE_IO_BRIDGE_STATS_EN
   ,
   output logic [15:0]   tx_words,
   output logic [15:0]   rx_words
`endif
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          rx_full_q, rx_full_d;
   logic [DW-1:0] rx_reg_q,  rx_reg_d;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic capture;
   logic consume;

   // Full blocks a push even if the head leaves in the same cycle.
   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign push       = core_wr && !fifo_full;
   assign pop        = !fifo_empty && host_tx_ready;
   assign capture    = host_rx_valid && !rx_full_q && sys_rst;
   assign consume    = core_rd && rx_full_q;

   assign host_tx_valid = !fifo_empty;
   assign host_tx_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign host_rx_ready = !rx_full_q && sys_rst;
   assign core_din      = rx_reg_q;
   assign core_din_vld  = rx_full_q;
   assign core_stall    = (core_wr && fifo_full) || (core_rd && !rx_full_q);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rx_full_d = rx_full_q;
      rx_reg_d  = rx_reg_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (capture) begin
         rx_full_d = 1'b1;
         rx_reg_d  = host_rx_data;
      end else if (consume) begin
         rx_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rx_full_q <= 1'b0;
         rx_reg_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rx_full_q <= rx_full_d;
         rx_reg_q  <= rx_reg_d;
      end
   end

   // Storage needs no reset: reads are masked by count.
   always_ff @(posedge clk) begin
      if (sys_rst && push) begin
         mem_q[wr_ptr_q] <= core_dout;
      end
   end

`ifdef CORE_IO_BRIDGE_STATS_EN
   logic [15:0] tx_words_q, tx_words_d;
   logic [15:0] rx_words_q, rx_words_d;

   always_comb begin
      tx_words_d = tx_words_q;
      rx_words_d = rx_words_q;
      if (pop && (tx_words_q != 16'hFFFF)) begin
         tx_words_d = tx_words_q + 16'd1;
      end
      if (capture && (rx_words_q != 16'hFFFF)) begin
         rx_words_d = rx_words_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         tx_words_q <= '0;
         rx_words_q <= '0;
      end else begin
         tx_words_q <= tx_words_d;
         rx_words_q <= rx_words_d;
      end
   end

   assign tx_words = tx_words_q;
   assign rx_words = rx_words_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_io_bridge.sv
// tb_core_io_bridge: table-driven checks of core_io_bridge with a TX scoreboard queue.
`default_nettype none

module tb_core_io_bridge;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic [15:0] core_dout = '0;
   logic        core_wr = 1'b0;
   logic        core_rd = 1'b0;
   logic [15:0] core_din;
   logic        core_din_vld;
   logic        core_stall;
   logic [15:0] host_tx_data;
   logic        host_tx_valid;
   logic        host_tx_ready = 1'b0;
   logic [15:0] host_rx_data = '0;
   logic        host_rx_valid = 1'b0;
   logic        host_rx_ready;
`ifdef CORE_IO_BRIDGE_STATS_EN
   logic [15:0] tx_words;
   logic [15:0] rx_words;
`endif

   core_io_bridge #(.DW(16), .DEPTH(4), .AW(2)) dut (
      .clk           (clk),
      .sys_rst       (sys_rst),
      .core_dout     (core_dout),
      .core_wr       (core_wr),
      .core_rd       (core_rd),
      .core_din      (core_din),
      .core_din_vld  (core_din_vld),
      .core_stall    (core_stall),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready)
`ifdef CORE_IO_BRIDGE_STATS_EN
      ,
      .tx_words      (tx_words),
      .rx_words      (rx_words)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] dout;
      logic        txr;
      logic        rxv;
      logic [15:0] rxd;
      logic        rd;
      logic        vld;
      logic        stall;
      logic        rdy;
      logic        dvld;
      logic [15:0] din;
   } vec_t;

   localparam int NV = 29;
   vec_t        tv [NV];
   logic [15:0] exp_q [$];
   int          total = 0;
   int          bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [15:0] dout, input logic txr,
                               input logic rxv, input logic [15:0] rxd, input logic rd,
                               input logic vld, input logic stall, input logic rdy,
                               input logic dvld, input logic [15:0] din);
      vec_t v;
      v.wr = wr; v.dout = dout; v.txr = txr; v.rxv = rxv; v.rxd = rxd; v.rd = rd;
      v.vld = vld; v.stall = stall; v.rdy = rdy; v.dvld = dvld; v.din = din;
      return v;
   endfunction

   // Pops the scoreboard whenever the host takes a word at the sampling point.
   task automatic sample_tx(input string tag);
      if (host_tx_valid && host_tx_ready) begin
         if (exp_q.size() == 0) begin
            check({tag, " unexpected pop"}, 32'(host_tx_data), 32'hDEAD_BEEF);
         end else begin
            check({tag, " tx_data"}, 32'(host_tx_data), 32'(exp_q.pop_front()));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      //            wr dout    txr rxv rxd      rd  vld stl rdy dvl din
      // TX order
      tv[0]  = mk(1, 16'd31, 0, 0, 16'h0,    0,  0, 0, 1, 0, 16'h0);
      tv[1]  = mk(1, 16'd32, 0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[2]  = mk(1, 16'd33, 0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[3]  = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[4]  = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[5]  = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[6]  = mk(0, 16'd0,  1, 0, 16'h0,    0,  0, 0, 1, 0, 16'h0);
      // Full and wrap
      tv[7]  = mk(1, 16'd1,  0, 0, 16'h0,    0,  0, 0, 1, 0, 16'h0);
      tv[8]  = mk(1, 16'd2,  0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[9]  = mk(1, 16'd3,  0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[10] = mk(1, 16'd4,  0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[11] = mk(1, 16'd5,  0, 0, 16'h0,    0,  1, 1, 1, 0, 16'h0);
      tv[12] = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[13] = mk(1, 16'd5,  0, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      // Push+pop at full is rejected, at count 2 both happen
      tv[14] = mk(1, 16'd9,  1, 0, 16'h0,    0,  1, 1, 1, 0, 16'h0);
      tv[15] = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[16] = mk(1, 16'd7,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[17] = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[18] = mk(0, 16'd0,  1, 0, 16'h0,    0,  1, 0, 1, 0, 16'h0);
      tv[19] = mk(0, 16'd0,  1, 0, 16'h0,    0,  0, 0, 1, 0, 16'h0);
      // RX path
      tv[20] = mk(0, 16'd0,  0, 1, 16'h00AA, 0,  0, 0, 1, 0, 16'h0);
      tv[21] = mk(0, 16'd0,  0, 0, 16'h0,    0,  0, 0, 0, 1, 16'h00AA);
      tv[22] = mk(0, 16'd0,  0, 0, 16'h0,    1,  0, 0, 0, 1, 16'h00AA);
      tv[23] = mk(0, 16'd0,  0, 0, 16'h0,    0,  0, 0, 1, 0, 16'h00AA);
      tv[24] = mk(0, 16'd0,  0, 0, 16'h0,    1,  0, 1, 1, 0, 16'h00AA);
      tv[25] = mk(0, 16'd0,  0, 1, 16'h1234, 0,  0, 0, 1, 0, 16'h00AA);
      tv[26] = mk(0, 16'd0,  0, 1, 16'h5678, 0,  0, 0, 0, 1, 16'h1234);
      tv[27] = mk(0, 16'd0,  0, 1, 16'h5678, 1,  0, 0, 0, 1, 16'h1234);
      tv[28] = mk(0, 16'd0,  0, 0, 16'h0,    0,  0, 0, 1, 0, 16'h1234);

      // Reset with active strobes must neither push nor capture
      sys_rst = 1'b0; core_wr = 1'b1; core_dout = 16'hBEEF;
      host_rx_valid = 1'b1; host_rx_data = 16'h5555;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst rx_ready", 32'(host_rx_ready), 32'd0);
      check("rst tx_valid", 32'(host_tx_valid), 32'd0);
      check("rst tx_data", 32'(host_tx_data), 32'd0);
      check("rst core_din", 32'(core_din), 32'd0);
      check("rst din_vld", 32'(core_din_vld), 32'd0);
      core_wr = 1'b0; host_rx_valid = 1'b0;
      @(posedge clk);
      #1;
      sys_rst = 1'b1;
      @(negedge clk);
      check("post-rst rx_ready", 32'(host_rx_ready), 32'd1);
      check("post-rst tx_valid", 32'(host_tx_valid), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         core_wr = tv[i].wr; core_dout = tv[i].dout; host_tx_ready = tv[i].txr;
         host_rx_valid = tv[i].rxv; host_rx_data = tv[i].rxd; core_rd = tv[i].rd;
         if (tv[i].wr && !tv[i].stall) exp_q.push_back(tv[i].dout);
         @(negedge clk);
         check($sformatf("v%0d tx_valid", i), 32'(host_tx_valid), 32'(tv[i].vld));
         check($sformatf("v%0d stall", i), 32'(core_stall), 32'(tv[i].stall));
         check($sformatf("v%0d rx_ready", i), 32'(host_rx_ready), 32'(tv[i].rdy));
         check($sformatf("v%0d din_vld", i), 32'(core_din_vld), 32'(tv[i].dvld));
         check($sformatf("v%0d core_din", i), 32'(core_din), 32'(tv[i].din));
         if (!tv[i].vld) check($sformatf("v%0d idle tx_data", i), 32'(host_tx_data), 32'd0);
         sample_tx($sformatf("v%0d", i));
         @(posedge clk);
         #1;
      end
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      core_wr = 1'b0; core_rd = 1'b0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;

`ifdef CORE_IO_BRIDGE_STATS_EN
      @(negedge clk);
      check("stats tx_words", 32'(tx_words), 32'd9);
      check("stats rx_words", 32'(rx_words), 32'd2);
      core_wr = 1'b1; core_dout = 16'h0042;
      @(posedge clk);
      #1;
      core_wr = 1'b0;
      @(negedge clk);
      force dut.tx_words_q = 16'hFFFF;
      #1;
      release dut.tx_words_q;
      host_tx_ready = 1'b1;
      @(posedge clk);
      #1;
      host_tx_ready = 1'b0;
      @(negedge clk);
      check("stats saturate", 32'(tx_words), 32'hFFFF);
      check("stats drained", 32'(host_tx_valid), 32'd0);
`endif

      // Reset mid-transfer discards buffered words and the RX word
      core_wr = 1'b1; core_dout = 16'h0A0A;
      host_rx_valid = 1'b1; host_rx_data = 16'h0B0B;
      @(posedge clk);
      #1;
      core_dout = 16'h0C0C; host_rx_valid = 1'b0;
      @(posedge clk);
      #1;
      core_wr = 1'b0;
      @(negedge clk);
      check("pre-rst tx_data", 32'(host_tx_data), 32'h0A0A);
      check("pre-rst din", 32'(core_din), 32'h0B0B);
      sys_rst = 1'b0;
      @(posedge clk);
      #1;
      sys_rst = 1'b1;
      @(negedge clk);
      check("mid-rst tx_valid", 32'(host_tx_valid), 32'd0);
      check("mid-rst din_vld", 32'(core_din_vld), 32'd0);
      check("mid-rst core_din", 32'(core_din), 32'd0);
      check("mid-rst rx_ready", 32'(host_rx_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
